// File: rtl/wb_cp0_stage_pkg.sv
// rtl/wb_cp0_stage_pkg.sv - shared types, bus layout, exception codes and CP0 addresses for the WB/CP0 stage
package wb_cp0_stage_pkg;

    localparam int MS_TO_WS_BUS_W = 118;

    typedef enum logic [3:0] {
        EXC_NONE     = 4'd0,
        EXC_INT      = 4'd1,
        EXC_ADEL_IF  = 4'd2,
        EXC_RI       = 4'd3,
        EXC_OV       = 4'd4,
        EXC_SYS      = 4'd5,
        EXC_BP       = 4'd6,
        EXC_ADEL_MEM = 4'd7,
        EXC_ADES     = 4'd8
    } exc_type_e;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    // {rd[4:0], sel[2:0]}
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

    typedef struct packed {
        logic [31:0] vaddr;
        logic        bd;
        logic        eret;
        logic [3:0]  exc_type;
        logic [7:0]  rd_sel;
        logic        res_from_cp0;
        logic        mtc0_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    function automatic logic [4:0] exc_code(input logic [3:0] t);
        case (t)
            EXC_ADEL_IF, EXC_ADEL_MEM: return EXCCODE_ADEL;
            EXC_ADES:                  return EXCCODE_ADES;
            EXC_SYS:                   return EXCCODE_SYS;
            EXC_BP:                    return EXCCODE_BP;
            EXC_RI:                    return EXCCODE_RI;
            EXC_OV:                    return EXCCODE_OV;
            default:                   return EXCCODE_INT;
        endcase
    endfunction

endpackage

// File: rtl/wb_cp0_stage_cp0_regfile.sv
// rtl/wb_cp0_stage_cp0_regfile.sv - CP0 state, read mux and exception/ERET/MTC0 updates
// Optional Count/Compare timer enabled by WB_TIMER_INT_EN.
module wb_cp0_stage_cp0_regfile
    import wb_cp0_stage_pkg::*;
#(
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_ext_int,
    input  logic        i_exc_valid,
    input  logic [3:0]  i_exc_type,
    input  logic        i_bd,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_vaddr,
    input  logic        i_eret,
    input  logic        i_mtc0_we,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_epc,
    output logic        o_has_int
);

    logic [31:0] r_badvaddr;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exccode;
    logic [31:0] r_epc;

    logic        w_ti;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;

    assign w_wr_status = i_mtc0_we && (i_addr == CP0_STATUS);
    assign w_wr_cause  = i_mtc0_we && (i_addr == CP0_CAUSE);
    assign w_wr_epc    = i_mtc0_we && (i_addr == CP0_EPC);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_status_im  <= STATUS_RST[15:8];
            r_status_exl <= STATUS_RST[1];
            r_status_ie  <= STATUS_RST[0];
        end else if (i_exc_valid) begin
            r_status_exl <= 1'b1;
        end else if (i_eret) begin
            r_status_exl <= 1'b0;
        end else if (w_wr_status) begin
            r_status_im  <= i_wdata[15:8];
            r_status_exl <= i_wdata[1];
            r_status_ie  <= i_wdata[0];
        end
    end

    // BD and EPC only latch for the first fault; nested faults under EXL keep the original return point
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cause_bd      <= 1'b0;
            r_cause_exccode <= 5'd0;
            r_cause_ip_sw   <= 2'd0;
        end else if (i_exc_valid) begin
            if (!r_status_exl) begin
                r_cause_bd <= i_bd;
            end
            r_cause_exccode <= exc_code(i_exc_type);
        end else if (w_wr_cause) begin
            r_cause_ip_sw <= i_wdata[9:8];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_epc <= 32'd0;
        end else if (i_exc_valid) begin
            if (!r_status_exl) begin
                r_epc <= i_bd ? (i_pc - 32'd4) : i_pc;
            end
        end else if (w_wr_epc) begin
            r_epc <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_badvaddr <= 32'd0;
        end else if (i_exc_valid) begin
            case (i_exc_type)
                EXC_ADEL_IF:            r_badvaddr <= i_pc;
                EXC_ADEL_MEM, EXC_ADES: r_badvaddr <= i_vaddr;
                default:                r_badvaddr <= r_badvaddr;
            endcase
        end
    end

`ifdef WB_TIMER_INT_EN
    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_cause_ti;
    logic        w_wr_count;
    logic        w_wr_compare;

    assign w_wr_count   = i_mtc0_we && (i_addr == CP0_COUNT);
    assign w_wr_compare = i_mtc0_we && (i_addr == CP0_COMPARE);

    // Count advances on every second clock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tick  <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr_count) begin
                r_count <= i_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_compare  <= 32'd0;
            r_cause_ti <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare  <= i_wdata;
            r_cause_ti <= 1'b0;
        end else if (r_count == r_compare) begin
            r_cause_ti <= 1'b1;
        end
    end

    assign w_ti      = r_cause_ti;
    assign w_count   = r_count;
    assign w_compare = r_compare;
`else
    assign w_ti      = 1'b0;
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
`endif

    assign w_status = (STATUS_RST & ~STATUS_WMASK)
                    | {16'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, w_ti, 14'd0, i_ext_int[5] | w_ti, i_ext_int[4:0],
                       r_cause_ip_sw, 1'b0, r_cause_exccode, 2'd0};

    always_comb begin
        o_rdata = 32'd0;
        case (i_addr)
            CP0_BADVADDR: o_rdata = r_badvaddr;
            CP0_COUNT:    o_rdata = w_count;
            CP0_COMPARE:  o_rdata = w_compare;
            CP0_STATUS:   o_rdata = w_status;
            CP0_CAUSE:    o_rdata = w_cause;
            CP0_EPC:      o_rdata = r_epc;
            default:      o_rdata = 32'd0;
        endcase
    end

    assign o_epc     = r_epc;
    assign o_has_int = (|(w_cause[15:8] & r_status_im)) && r_status_ie && !r_status_exl;

endmodule

// File: rtl/wb_cp0_stage.sv
// rtl/wb_cp0_stage.sv - MIPS write-back stage: bus register, GPR commit, trace ports, CP0 hookup
// Optional Count/Compare timer enabled by WB_TIMER_INT_EN.
module wb_cp0_stage
    import wb_cp0_stage_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY  = 32'hbfc0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ms_to_ws_valid,
    input  logic [MS_TO_WS_BUS_W-1:0] ms_to_ws_bus,
    output logic                      ws_allowin,
    input  logic [5:0]                ext_int,
    output logic                      rf_we,
    output logic [4:0]                rf_waddr,
    output logic [31:0]               rf_wdata,
    output logic                      ws_ex,
    output logic                      eret_flush,
    output logic [31:0]               ws_flush_pc,
    output logic                      has_int,
    output logic                      out_ws_valid,
    output logic [31:0]               debug_wb_pc,
    output logic [3:0]                debug_wb_rf_wen,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [31:0]               debug_wb_rf_wdata
);

    logic          r_ws_valid;
    ms_to_ws_bus_t r_bus;

    logic          w_ready_go;
    logic          w_ws_ex;
    logic          w_eret_flush;
    logic          w_mtc0_we;
    logic          w_rf_we;
    logic [31:0]   w_rf_wdata;
    logic [31:0]   w_cp0_rdata;
    logic [31:0]   w_epc;

    assign w_ready_go = 1'b1;
    assign ws_allowin = !r_ws_valid || w_ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            r_ws_valid <= ms_to_ws_valid;
        end
    end

    // Bus is cleared on reset so every trace/RF output reads zero until the first instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus <= '0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            r_bus <= ms_to_ws_bus;
        end
    end

    assign w_ws_ex      = r_ws_valid && (r_bus.exc_type != EXC_NONE);
    assign w_eret_flush = r_ws_valid && r_bus.eret && !w_ws_ex;
    assign w_mtc0_we    = r_ws_valid && r_bus.mtc0_we && !w_ws_ex;
    assign w_rf_we      = r_ws_valid && r_bus.gr_we && !w_ws_ex;
    assign w_rf_wdata   = r_bus.res_from_cp0 ? w_cp0_rdata : r_bus.result;

    wb_cp0_stage_cp0_regfile #(
        .STATUS_RST (STATUS_RST)
    ) u_cp0 (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_ext_int   (ext_int),
        .i_exc_valid (w_ws_ex),
        .i_exc_type  (r_bus.exc_type),
        .i_bd        (r_bus.bd),
        .i_pc        (r_bus.pc),
        .i_vaddr     (r_bus.vaddr),
        .i_eret      (w_eret_flush),
        .i_mtc0_we   (w_mtc0_we),
        .i_addr      (r_bus.rd_sel),
        .i_wdata     (r_bus.result),
        .o_rdata     (w_cp0_rdata),
        .o_epc       (w_epc),
        .o_has_int   (has_int)
    );

    assign ws_ex        = w_ws_ex;
    assign eret_flush   = w_eret_flush;
    assign ws_flush_pc  = w_ws_ex ? EXC_ENTRY : (w_eret_flush ? w_epc : 32'd0);
    assign out_ws_valid = r_ws_valid;

    assign rf_we    = w_rf_we;
    assign rf_waddr = r_bus.dest;
    assign rf_wdata = w_rf_wdata;

    assign debug_wb_pc       = r_bus.pc;
    assign debug_wb_rf_wen   = {4{w_rf_we}};
    assign debug_wb_rf_wnum  = r_bus.dest;
    assign debug_wb_rf_wdata = w_rf_wdata;

endmodule

// File: tb/tb_wb_cp0_stage.sv
// tb/tb_wb_cp0_stage.sv - randomized bench for wb_cp0_stage against a behavioural CP0 model
module tb_wb_cp0_stage;
    import wb_cp0_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_to_ws_valid;
    logic [117:0] ms_to_ws_bus;
    logic [5:0]   ext_int;
    logic         ws_allowin, rf_we, ws_ex, eret_flush, has_int, out_ws_valid;
    logic [4:0]   rf_waddr, debug_wb_rf_wnum;
    logic [31:0]  rf_wdata, ws_flush_pc, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]   debug_wb_rf_wen;

    wb_cp0_stage dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin), .ext_int(ext_int), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .ws_ex(ws_ex), .eret_flush(eret_flush), .ws_flush_pc(ws_flush_pc),
        .has_int(has_int), .out_ws_valid(out_ws_valid), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: instruction in WB plus CP0 kept as architectural register images
    logic          m_valid;
    ms_to_ws_bus_t m_bus;
    logic [31:0]   m_status, m_epc, m_bad, m_count, m_compare;
    logic          m_bd, m_ti, m_tick;
    logic [1:0]    m_sw;
    logic [4:0]    m_code;
    logic [4:0]    code_tbl [0:8] = '{5'd0, 5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};

    function automatic logic [31:0] m_cause();
        logic [31:0] ip;
        ip = 32'(ext_int) | (m_ti ? 32'h20 : 32'h0);
        return (m_bd ? 32'h8000_0000 : 32'h0) | (m_ti ? 32'h4000_0000 : 32'h0)
             | (ip << 10) | (32'(m_sw) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h40:   return m_bad;
            8'h48:   return m_count;
            8'h58:   return m_compare;
            8'h60:   return m_status;
            8'h68:   return m_cause();
            8'h70:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_is_ex();
        return m_valid && (m_bus.exc_type != 4'd0);
    endfunction

    logic u_ex, u_er, u_wr, u_exl;
    logic [31:0] u_cnt, u_cmp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0; m_bus = '0; m_status = 32'h0040_0000; m_epc = 0; m_bad = 0;
            m_count = 0; m_compare = 0; m_bd = 0; m_ti = 0; m_tick = 0; m_sw = 0; m_code = 0;
        end else begin
            u_ex  = m_is_ex();
            u_er  = m_valid && m_bus.eret && !u_ex;
            u_wr  = m_valid && m_bus.mtc0_we && !u_ex;
            u_exl = m_status[1];
            u_cnt = m_count;
            u_cmp = m_compare;
            if (u_ex) begin
                if (!u_exl) begin
                    m_epc = m_bus.pc - (m_bus.bd ? 32'd4 : 32'd0);
                    m_bd  = m_bus.bd;
                end
                m_status = m_status | 32'h2;
                m_code   = code_tbl[m_bus.exc_type];
                if (m_bus.exc_type == 4'd2) m_bad = m_bus.pc;
                else if (m_bus.exc_type == 4'd7 || m_bus.exc_type == 4'd8) m_bad = m_bus.vaddr;
            end else if (u_er) begin
                m_status = m_status & ~32'h2;
            end else if (u_wr) begin
                if (m_bus.rd_sel == 8'h60) m_status = (m_bus.result & 32'h0000_ff03) | 32'h0040_0000;
                if (m_bus.rd_sel == 8'h68) m_sw = m_bus.result[9:8];
                if (m_bus.rd_sel == 8'h70) m_epc = m_bus.result;
            end
`ifdef WB_TIMER_INT_EN
            if (u_wr && m_bus.rd_sel == 8'h58) begin
                m_compare = m_bus.result;
                m_ti = 1'b0;
            end else if (u_cnt == u_cmp) begin
                m_ti = 1'b1;
            end
            if (u_wr && m_bus.rd_sel == 8'h48) m_count = m_bus.result;
            else if (m_tick) m_count = u_cnt + 32'd1;
            m_tick = !m_tick;
`endif
            m_valid = ms_to_ws_valid;
            if (ms_to_ws_valid) m_bus = ms_to_ws_bus;
        end
    end

    logic        e_ex, e_er, e_we;
    logic [31:0] e_wdata, e_flush;
    logic        e_int;

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            e_ex    = m_is_ex();
            e_er    = m_valid && m_bus.eret && !e_ex;
            e_we    = m_valid && m_bus.gr_we && !e_ex;
            e_wdata = m_bus.res_from_cp0 ? m_read(m_bus.rd_sel) : m_bus.result;
            e_flush = e_ex ? 32'hbfc0_0380 : (e_er ? m_epc : 32'h0);
            e_int   = ((((m_cause() >> 8) & (m_status >> 8)) & 32'hff) != 0) && m_status[0] && !m_status[1];
            cmp("allowin", 32'(ws_allowin), 32'd1);
            cmp("ws_valid", 32'(out_ws_valid), 32'(m_valid));
            cmp("ws_ex", 32'(ws_ex), 32'(e_ex));
            cmp("eret_flush", 32'(eret_flush), 32'(e_er));
            cmp("has_int", 32'(has_int), 32'(e_int));
            cmp("rf_we", 32'(rf_we), 32'(e_we));
            cmp("dbg_wen", 32'(debug_wb_rf_wen), e_we ? 32'hf : 32'h0);
            cmp("flush_pc", ws_flush_pc, e_flush);
            if (e_we) begin
                cmp("rf_waddr", 32'(rf_waddr), 32'(m_bus.dest));
                cmp("rf_wdata", rf_wdata, e_wdata);
                cmp("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(m_bus.dest));
                cmp("dbg_wdata", debug_wb_rf_wdata, e_wdata);
            end
            if (m_valid) cmp("dbg_pc", debug_wb_pc, m_bus.pc);
        end
    end

    ms_to_ws_bus_t b;
    logic [7:0] sel_tbl [0:6] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h61};

    task automatic issue(input ms_to_ws_bus_t bb, input logic v);
        ms_to_ws_valid = v;
        ms_to_ws_bus   = bb;
        @(posedge clk);
        #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic mfc0(input logic [7:0] a);
        ms_to_ws_bus_t t;
        t = '0; t.pc = 32'hbfc0_0400; t.gr_we = 1'b1; t.res_from_cp0 = 1'b1; t.rd_sel = a; t.dest = 5'd3;
        issue(t, 1'b1);
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        ms_to_ws_bus_t t;
        t = '0; t.pc = 32'hbfc0_0500; t.mtc0_we = 1'b1; t.rd_sel = a; t.result = d;
        issue(t, 1'b1);
    endtask

    initial begin
        reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; ext_int = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_valid", 32'(out_ws_valid), 32'd0);
        cmp("rst_rf_we", 32'(rf_we), 32'd0);
        cmp("rst_ex", 32'(ws_ex | eret_flush), 32'd0);
        cmp("rst_has_int", 32'(has_int), 32'd0);
        cmp("rst_flush_pc", ws_flush_pc, 32'd0);
        cmp("rst_dbg_pc", debug_wb_pc, 32'd0);
        cmp("rst_wdata", rf_wdata, 32'd0);
        cmp("rst_allowin", 32'(ws_allowin), 32'd1);
        reset = 1'b0;
        chk_en = 1'b1;

        b = '0; b.pc = 32'hbfc0_0000; b.gr_we = 1'b1; b.dest = 5'd5; b.result = 32'h1234;
        issue(b, 1'b1);
        cmp("lw_we", 32'(rf_we), 32'd1);
        cmp("lw_waddr", 32'(rf_waddr), 32'd5);
        cmp("lw_wdata", rf_wdata, 32'h1234);
        cmp("lw_dbg_wen", 32'(debug_wb_rf_wen), 32'hf);

        b = '0; b.pc = 32'hbfc0_0100; b.bd = 1'b1; b.exc_type = 4'd5; b.gr_we = 1'b1;
        issue(b, 1'b1);
        cmp("sys_ex", 32'(ws_ex), 32'd1);
        cmp("sys_rf_we", 32'(rf_we), 32'd0);
        cmp("sys_flush_pc", ws_flush_pc, 32'hbfc0_0380);
        mfc0(8'h70);
        cmp("sys_epc", rf_wdata, 32'hbfc0_00fc);
        mfc0(8'h68);
        cmp("sys_cause", rf_wdata & 32'h8000_007c, 32'h8000_0020);

        b = '0; b.pc = 32'hbfc0_0180; b.exc_type = 4'd8; b.vaddr = 32'h8000_0003;
        issue(b, 1'b1);
        mfc0(8'h40);
        cmp("ades_badv", rf_wdata, 32'h8000_0003);
        mfc0(8'h70);
        cmp("ades_epc_kept", rf_wdata, 32'hbfc0_00fc);
        mfc0(8'h68);
        cmp("ades_code", rf_wdata & 32'h7c, 32'h14);

        mtc0(8'h60, 32'h0000_ff01);
        ext_int = 6'b000100;
        issue('0, 1'b0);
        cmp("int_has_int", 32'(has_int), 32'd1);
        mtc0(8'h60, 32'h0000_ff03);
        issue('0, 1'b0);
        cmp("int_exl_mask", 32'(has_int), 32'd0);
        mtc0(8'h70, 32'hbfc0_0200);
        b = '0; b.pc = 32'hbfc0_0600; b.eret = 1'b1;
        issue(b, 1'b1);
        cmp("eret_flush", 32'(eret_flush), 32'd1);
        cmp("eret_pc", ws_flush_pc, 32'hbfc0_0200);
        mfc0(8'h60);
        cmp("eret_status", rf_wdata, 32'h0040_ff01);
        ext_int = 6'd0;

`ifdef WB_TIMER_INT_EN
        mtc0(8'h48, 32'h100);
        mtc0(8'h58, 32'd4);
        mtc0(8'h48, 32'd0);
        mfc0(8'h68);
        cmp("ti_clear", rf_wdata & 32'h4000_8000, 32'h0);
        repeat (12) issue('0, 1'b0);
        mfc0(8'h68);
        cmp("ti_set", rf_wdata & 32'h4000_8000, 32'h4000_8000);
        mtc0(8'h58, 32'h1000);
        mfc0(8'h68);
        cmp("ti_mtc0_clr", rf_wdata & 32'h4000_0000, 32'h0);
`else
        mtc0(8'h48, 32'h55);
        mfc0(8'h48);
        cmp("count_absent", rf_wdata, 32'h0);
        mtc0(8'h58, 32'h7);
        mfc0(8'h58);
        cmp("compare_absent", rf_wdata, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            b = '0;
            b.pc       = $urandom & 32'hffff_fffc;
            b.vaddr    = $urandom;
            b.result   = $urandom;
            b.dest     = 5'($urandom);
            b.bd       = 1'($urandom);
            b.exc_type = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 8)) : 4'd0;
            b.eret     = ($urandom_range(0, 7) == 0);
            b.mtc0_we  = !b.eret && ($urandom_range(0, 3) == 0);
            b.res_from_cp0 = !b.mtc0_we && ($urandom_range(0, 2) == 0);
            b.gr_we    = b.res_from_cp0 ? 1'b1 : (b.mtc0_we ? 1'b0 : 1'($urandom));
            if ($urandom_range(0, 7) == 7) b.rd_sel = 8'($urandom);
            else b.rd_sel = sel_tbl[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) ext_int = 6'($urandom);
            issue(b, $urandom_range(0, 4) != 0);
        end

        b = '0; b.pc = 32'hbfc0_0700; b.gr_we = 1'b1; b.dest = 5'd9; b.result = 32'hdead;
        issue(b, 1'b1);
        ms_to_ws_valid = 1'b1;
        ms_to_ws_bus = b;
        #2;
        reset = 1'b1;
        #1;
        cmp("mid_rst_valid", 32'(out_ws_valid), 32'd0);
        cmp("mid_rst_rf_we", 32'(rf_we), 32'd0);
        cmp("mid_rst_wen", 32'(debug_wb_rf_wen), 32'd0);
        cmp("mid_rst_has_int", 32'(has_int), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ms_to_ws_valid = 1'b0;
        mfc0(8'h60);
        cmp("mid_rst_status", rf_wdata, 32'h0040_0000);
        mfc0(8'h70);
        cmp("mid_rst_epc", rf_wdata, 32'h0);
        issue('0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
